sel_a2f: RTL

SEL_A2F -- requirements
Module: sel_a2f

---
 rtl/sel_a2f.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/sel_a2f.sv
// sel_a2f: merges IQ sample bursts and CPU response packets into one FTDI
// transmit word stream. Every packet is a header word followed by payload
// words. CPU requests win over IQ bursts, and a packet always runs to its end.
// The output register holds its word while the transmit path reports full.
// Optional feature: define SEL_A2F_SIGN_EXT_EN to sign-extend the 12-bit
// I and Q fields of IQ payload words into the unused nibbles above them.
module sel_a2f #(
    parameter int FT_DATA_WIDTH    = 32,
    parameter int IQ_PAIR_WIDTH    = 24,
    parameter int QSTART_BIT_INDEX = 16,
    parameter int BURST_LEN        = 256
) (
    input  logic                     clk_i,
    input  logic                     reset,
    input  logic                     loopback,
    input  logic [IQ_PAIR_WIDTH-1:0] iq_data_i,
    input  logic                     iq_empty_i,
    input  logic                     iq_enough_i,
    output logic                     iq_re_o,
    input  logic                     cpu_req_i,
    input  logic [7:0]               cpu_len_i,
    input  logic [FT_DATA_WIDTH-1:0] cpu_data_i,
    input  logic                     cpu_empty_i,
    output logic                     cpu_re_o,
    output logic [FT_DATA_WIDTH-1:0] data_o,
    output logic                     we_o,
    input  logic                     full_i
);

    // The *_HDR states mean "header word now sits in the output register".
    // The next load from a *_HDR state is the first payload word.
    typedef enum logic [2:0] {IDLE, IQ_HDR, IQ_DATA, CPU_HDR, CPU_DATA} state_t;

    localparam logic [15:0] LP_BURST = 16'(BURST_LEN);

    state_t                   r_state, w_next_state;
    logic [15:0]              r_cnt, w_next_cnt;
    logic [7:0]               r_len, w_next_len;
    logic [FT_DATA_WIDTH-1:0] r_data, w_next_data;
    logic                     r_we, w_next_we;
    logic                     w_load;
    logic                     w_iq_pop, w_cpu_pop;
    logic [15:0]              w_cnt_inc;
    logic [FT_DATA_WIDTH-1:0] w_iq_word, w_iq_hdr, w_cpu_hdr;

    // The output register may take a new word when it is empty or draining.
    assign w_load    = !r_we || !full_i;
    assign w_cnt_inc = r_cnt + 16'd1;

    // Build the header words and the reformatted IQ payload word.
    always_comb begin
        w_iq_hdr        = '0;
        w_iq_hdr[15:0]  = LP_BURST;
        w_cpu_hdr       = '0;
        w_cpu_hdr[31]   = 1'b1;
        w_cpu_hdr[27:20] = cpu_len_i;
        w_iq_word       = '0;
        w_iq_word[QSTART_BIT_INDEX +: 12] = iq_data_i[23:12];
        w_iq_word[11:0] = iq_data_i[11:0];
`ifdef SEL_A2F_SIGN_EXT_EN
        w_iq_word[31:28] = {4{iq_data_i[23]}};
        w_iq_word[15:12] = {4{iq_data_i[11]}};
`else
        w_iq_word[31:28] = 4'h0;
        w_iq_word[15:12] = 4'h0;
`endif
    end

    // Next-state, output register and FIFO pop decode.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_len   = r_len;
        w_next_data  = r_data;
        w_next_we    = r_we;
        w_iq_pop     = 1'b0;
        w_cpu_pop    = 1'b0;
        if (w_load) begin
            // Without a new word the current one is consumed and the output goes idle.
            w_next_we = 1'b0;
            case (r_state)
                IDLE: begin
                    if (cpu_req_i) begin
                        w_next_data  = w_cpu_hdr;
                        w_next_we    = 1'b1;
                        w_next_len   = cpu_len_i;
                        w_next_cnt   = 16'd0;
                        w_next_state = (cpu_len_i == 8'd0) ? IDLE : CPU_HDR;
                    end else if (iq_enough_i) begin
                        w_next_data  = w_iq_hdr;
                        w_next_we    = 1'b1;
                        w_next_cnt   = 16'd0;
                        w_next_state = IQ_HDR;
                    end
                end
                IQ_HDR, IQ_DATA: begin
                    if (!iq_empty_i) begin
                        w_next_data  = w_iq_word;
                        w_next_we    = 1'b1;
                        w_iq_pop     = 1'b1;
                        w_next_cnt   = w_cnt_inc;
                        w_next_state = (w_cnt_inc == LP_BURST) ? IDLE : IQ_DATA;
                    end
                end
                CPU_HDR, CPU_DATA: begin
                    if (!cpu_empty_i) begin
                        w_next_data  = cpu_data_i;
                        w_next_we    = 1'b1;
                        w_cpu_pop    = 1'b1;
                        w_next_cnt   = w_cnt_inc;
                        w_next_state = (w_cnt_inc == {8'h00, r_len}) ? IDLE : CPU_DATA;
                    end
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    // State, counter, length and output register; loopback acts as a reset.
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 16'd0;
            r_len   <= 8'd0;
            r_data  <= '0;
            r_we    <= 1'b0;
        end else if (loopback) begin
            r_state <= IDLE;
            r_cnt   <= 16'd0;
            r_len   <= 8'd0;
            r_data  <= '0;
            r_we    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_len   <= w_next_len;
            r_data  <= w_next_data;
            r_we    <= w_next_we;
        end
    end

    assign iq_re_o  = w_iq_pop  && !loopback && !reset;
    assign cpu_re_o = w_cpu_pop && !loopback && !reset;
    assign data_o   = r_data;
    assign we_o     = r_we;

endmodule
